// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one single-port 64-bit data RAM between the memory stage (D, read/write)
// and instruction fetch (I, read-only), one access per IDLE -> ACCESS -> RESP pass.
module dmem_port_arbiter #(
   parameter int ADDR_W       = 7,
   parameter int DEPTH        = 128,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [63:0]       d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [63:0]       d_rdata,
   output logic              d_err,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_gnt,
   output logic              i_rvalid,
   output logic [63:0]       i_rdata,
   output logic              i_err,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [63:0]       ram_wdata,
   input  logic [63:0]       ram_rdata,
   output logic              busy
);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} stateT;
   localparam logic [ADDR_W:0] LIMIT  = (ADDR_W+1)'(DEPTH);
   localparam logic [7:0]      STARVE = 8'(STARVE_LIMIT);

   stateT             state, nextState;
   logic              ownerI, weQ, errQ;
   logic [7:0]        starveCnt;
   logic [63:0]       dRdataQ, iRdataQ, respData, arbWdata;
   logic              start, pickI, arbWe, arbInRange, respD, respI;
   logic [ADDR_W-1:0] arbAddr;

   always_comb begin
      start      = (state == IDLE) & (d_req | i_req);
      pickI      = i_req & (~d_req | (STARVE != 8'd0 & starveCnt >= STARVE));
      arbWe      = ~pickI & d_we;
      arbAddr    = pickI ? i_addr : d_addr;
      arbWdata   = pickI ? '0 : d_wdata;
      arbInRange = {1'b0, arbAddr} < LIMIT;
      nextState  = start ? ACCESS : state == ACCESS ? RESP : IDLE;
      respD      = state == RESP & ~ownerI;
      respI      = state == RESP & ownerI;
      respData   = errQ ? '0 : ram_rdata;
   end

   assign d_gnt    = state == ACCESS & ~ownerI;
   assign i_gnt    = state == ACCESS & ownerI;
   assign d_rvalid = respD;
   assign i_rvalid = respI;
   assign d_err    = respD & errQ;
   assign i_err    = respI & errQ;
   // RAM data arrives during RESP, so it is forwarded live and captured for holding at the edge ending RESP.
   assign d_rdata  = respD & (errQ | ~weQ) ? respData : dRdataQ;
   assign i_rdata  = respI ? respData : iRdataQ;
   assign busy     = state != IDLE;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state     <= IDLE;
         ownerI    <= 1'b0;
         weQ       <= 1'b0;
         errQ      <= 1'b0;
         starveCnt <= '0;
         dRdataQ   <= '0;
         iRdataQ   <= '0;
         ram_en    <= 1'b0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
      end else begin
         state  <= nextState;
         ram_en <= start & arbInRange;
         ram_we <= start & arbInRange & arbWe;
         if (start) begin
            ownerI    <= pickI;
            weQ       <= arbWe;
            errQ      <= ~arbInRange;
            ram_addr  <= arbAddr;
            ram_wdata <= arbWdata;
            starveCnt <= pickI ? '0 : (i_req && starveCnt != 8'hFF) ? starveCnt + 8'd1 : starveCnt;
         end
         if (respD & (errQ | ~weQ)) dRdataQ <= respData;
         if (respI) iRdataQ <= respData;
      end
   end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed and randomized checks of dmem_port_arbiter against a
// transaction-level model (reference memory, per-port read data, starvation count).
module tb_dmem_port_arbiter;
   localparam int DEPTH = 100;
   localparam int LIMIT = 4;

   logic clock = 1'b0;
   logic reset_n;
   logic d_req, d_we, d_gnt, d_rvalid, d_err;
   logic [6:0] d_addr;
   logic [63:0] d_wdata, d_rdata;
   logic i_req, i_gnt, i_rvalid, i_err;
   logic [6:0] i_addr;
   logic [63:0] i_rdata;
   logic ram_en, ram_we, busy;
   logic [6:0] ram_addr;
   logic [63:0] ram_wdata;
   logic [63:0] ram_rdata = '0;

   int nChecks = 0;
   int nErrors = 0;
   int cyc = 0;
   int mStarve = 0;
   logic [63:0] mDRdata = '0;
   logic [63:0] mIRdata = '0;
   logic [63:0] refMem [128];
   logic [63:0] mem [128];
   bit loaded = 1'b0;

   dmem_port_arbiter #(.ADDR_W(7), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .clock(clock), .reset_n(reset_n),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
      .i_req(i_req), .i_addr(i_addr),
      .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .busy(busy)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   function automatic logic [63:0] initVal(input int i);
      return 64'hA5A5_0000_0000_0000 + 64'(i) * 64'h0001_0001;
   endfunction

   // RAM macro stand-in: one-cycle read latency, preloaded on the first edge.
   always @(posedge clock) begin
      if (!loaded) begin
         for (int i = 0; i < 128; i++) mem[i] <= initVal(i);
         loaded <= 1'b1;
      end else if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_wdata;
         ram_rdata <= mem[ram_addr];
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nChecks++;
      if (got !== exp) begin
         nErrors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // One arbitration from IDLE with whatever requests are currently raised.
   task automatic runAccess();
      bit iWins, we, inR;
      logic [6:0] addr;
      logic [63:0] wd;
      iWins = i_req && (!d_req || mStarve >= LIMIT);
      if (d_req && i_req) mStarve = iWins ? 0 : mStarve + 1;
      else if (i_req) mStarve = 0;
      addr = iWins ? i_addr : d_addr;
      we = !iWins && d_we;
      wd = d_wdata;
      inR = addr < DEPTH;
      check("pre_gnt", {d_gnt, i_gnt, busy}, 3'b000);
      step();
      check("gnt", {d_gnt, i_gnt}, iWins ? 2'b01 : 2'b10);
      check("ram_en", ram_en, inR);
      check("ram_we", ram_we, inR && we);
      if (inR) check("ram_addr", ram_addr, addr);
      if (inR && we) check("ram_wdata", ram_wdata, wd);
      if (iWins) begin
         i_req = 1'b0;
         i_addr = 7'($urandom_range(0, 127));
      end else begin
         d_req = 1'b0;
         d_we = 1'($urandom_range(0, 1));
         d_addr = 7'($urandom_range(0, 127));
         d_wdata = {$urandom, $urandom};
      end
      step();
      if (iWins) mIRdata = inR ? refMem[addr] : '0;
      else if (!inR) mDRdata = '0;
      else if (we) refMem[addr] = wd;
      else mDRdata = refMem[addr];
      check("rvalid", {d_rvalid, i_rvalid}, iWins ? 2'b01 : 2'b10);
      check("err", {d_err, i_err}, inR ? 2'b00 : iWins ? 2'b01 : 2'b10);
      check("d_rdata", d_rdata, mDRdata);
      check("i_rdata", i_rdata, mIRdata);
      check("resp_ram", {ram_en, ram_we}, 2'b00);
      step();
   endtask

   task automatic single(input bit isI, input bit we, input logic [6:0] addr, input logic [63:0] wd);
      if (isI) begin
         i_req = 1'b1;
         i_addr = addr;
      end else begin
         d_req = 1'b1;
         d_we = we;
         d_addr = addr;
         d_wdata = wd;
      end
      runAccess();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d", nChecks);
      $fatal(1);
   end

   initial begin
      bit iw;
      int last;
      logic [63:0] wv;
      for (int i = 0; i < 128; i++) refMem[i] = initVal(i);
      reset_n = 1'b0;
      d_req = 1'b1; d_we = 1'b1; d_addr = 7'd5; d_wdata = 64'hFFFF;
      i_req = 1'b1; i_addr = 7'd9;
      step();
      step();
      check("rst_ctl", {d_gnt, i_gnt, d_rvalid, i_rvalid, d_err, i_err, ram_en, ram_we, busy}, 9'd0);
      check("rst_d_rdata", d_rdata, '0);
      check("rst_i_rdata", i_rdata, '0);
      check("rst_ram_addr", ram_addr, '0);
      check("rst_ram_wdata", ram_wdata, '0);
      d_req = 1'b0; i_req = 1'b0;
      reset_n = 1'b1;
      step();

      single(0, 1, 7'd5, 64'h0F);
      single(0, 0, 7'd5, '0);
      check("wr_rd_5", d_rdata, 64'h0F);

      d_we = 1'b0; d_addr = 7'd10; i_addr = 7'd20;
      d_req = 1'b1; i_req = 1'b1;
      for (int g = 0; g < 10; g++) begin
         for (int n = 0; n < 6 && !(d_gnt || i_gnt); n++) step();
         iw = (g % 5 == 4);
         check("contend_gnt", {d_gnt, i_gnt}, iw ? 2'b01 : 2'b10);
         mStarve = iw ? 0 : mStarve + 1;
         if (g == 9) begin
            d_req = 1'b0;
            i_req = 1'b0;
         end
         step();
         if (iw) mIRdata = refMem[20];
         else mDRdata = refMem[10];
         check("contend_d_rdata", d_rdata, mDRdata);
         check("contend_i_rdata", i_rdata, mIRdata);
      end
      step();

      single(1, 0, 7'd127, '0);
      check("err_i_rdata", i_rdata, '0);
      single(0, 0, 7'd99, '0);
      single(0, 0, 7'd100, '0);
      single(0, 1, 7'd100, 64'hDEAD);
      single(1, 0, 7'd99, '0);

      single(0, 0, 7'd7, '0);
      d_we = 1'b0; d_addr = 7'd8; d_req = 1'b1;
      step();
      check("rst_mid_gnt", d_gnt, 1'b1);
      d_req = 1'b0;
      reset_n = 1'b0;
      step();
      check("rst_mid_rvalid", {d_rvalid, i_rvalid, busy}, 3'b000);
      check("rst_mid_d_rdata", d_rdata, '0);
      mDRdata = '0; mIRdata = '0; mStarve = 0;
      reset_n = 1'b1;
      step();
      wv = 64'h1234_5678_9ABC_DEF0;
      d_we = 1'b1; d_addr = 7'd9; d_wdata = wv; d_req = 1'b1;
      step();
      check("rst_wr_gnt", d_gnt, 1'b1);
      d_req = 1'b0;
      reset_n = 1'b0;
      step();
      check("rst_wr_rvalid", d_rvalid, 1'b0);
      refMem[9] = wv;
      reset_n = 1'b1;
      step();
      single(0, 0, 7'd9, '0);
      single(0, 0, 7'd3, '0);

      i_req = 1'b1; i_addr = 7'd0; last = 0;
      for (int a = 0; a < 4; a++) begin
         for (int n = 0; n < 6 && !i_gnt; n++) step();
         check("b2b_gnt", i_gnt, 1'b1);
         if (a > 0) check("b2b_spacing", 64'(cyc - last), 64'd3);
         last = cyc;
         mStarve = 0;
         if (a == 3) i_req = 1'b0;
         else i_addr = 7'(a + 1);
         step();
         mIRdata = refMem[a];
         check("b2b_rvalid", i_rvalid, 1'b1);
         check("b2b_rdata", i_rdata, mIRdata);
      end
      step();

      repeat (250) begin
         if (!d_req && $urandom_range(0, 1) == 1) d_req = 1'b1;
         if (!i_req && $urandom_range(0, 1) == 1) i_req = 1'b1;
         if (!d_req && !i_req) begin
            check("rnd_idle", {d_gnt, i_gnt, busy}, 3'b000);
            step();
         end else runAccess();
      end

      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end
endmodule
